// File: rtl/unix_datetime_decoder_pkg.sv
// Shared definitions for the unix_datetime_decoder block.
//   state_t      : controller states of the decoder FSM
//   constants    : epoch, seconds-per-unit and upper range limit
//   month_len    : days in a month given the leap flag
//   mod7_add     : (a + b) mod 7 for operands already reduced below 7
package unix_datetime_decoder_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    DIVDAY,
    HOUR,
    MIN,
    YEAR,
    MONTH,
    WDAY,
    DONE
  } state_t;

  localparam logic [16:0] SEC_PER_DAY  = 17'd86400;
  localparam logic [16:0] SEC_PER_HOUR = 17'd3600;
  localparam logic [16:0] SEC_PER_MIN  = 17'd60;
  localparam logic [11:0] EPOCH_YEAR   = 12'd1970;
  localparam logic [2:0]  EPOCH_WDAY   = 3'd4;
  // 2100-01-01 00:00:00 UTC; first instant outside the supported range.
  localparam logic [31:0] MAX_UNIX     = 32'd4102444800;

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
    logic [4:0] len;
    case (m)
      4'd2:                    len = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
      default:                 len = 5'd31;
    endcase
    return len;
  endfunction

  function automatic logic [2:0] mod7_add(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
  endfunction

endpackage

// File: rtl/unix_datetime_decoder_if.sv
// Request/result bundle of the unix_datetime_decoder.
//   start/unix_time              : request, driven by the master
//   busy/done/err                : status, driven by the decoder
//   year..second/weekday         : decoded calendar result
interface unix_datetime_decoder_if #(
  parameter int N = 64
);
  logic         start;
  logic [N-1:0] unix_time;
  logic         busy;
  logic         done;
  logic         err;
  logic [11:0]  year;
  logic [3:0]   month;
  logic [4:0]   day;
  logic [4:0]   hour;
  logic [5:0]   minute;
  logic [5:0]   second;
  logic [2:0]   weekday;

  modport master (
    output start, unix_time,
    input  busy, done, err, year, month, day, hour, minute, second, weekday
  );

  modport slave (
    input  start, unix_time,
    output busy, done, err, year, month, day, hour, minute, second, weekday
  );
endinterface

// File: rtl/udiv_seq.sv
// Sequential restoring divider, one quotient bit per cycle.
//   clk, reset    : clock, synchronous active-high reset
//   i_start       : loads dividend/divisor and begins a 32-cycle division
//   i_dividend    : 32-bit dividend
//   i_divisor     : 17-bit divisor (must be nonzero)
//   o_done        : one-cycle pulse once quotient/remainder are valid
//   o_quotient    : 32-bit quotient
//   o_remainder   : 17-bit remainder
module udiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_dividend,
  input  logic [16:0] i_divisor,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [16:0] o_remainder
);

  logic [31:0] r_quo;
  logic [16:0] r_rem;
  logic [16:0] r_div;
  logic [4:0]  r_cnt;
  logic        r_run;
  logic        r_done;

  logic [17:0] w_shift;
  logic        w_ge;
  logic [16:0] w_diff;

  // The partial remainder is always below the divisor, so after the
  // subtraction the result fits in 17 bits and modular arithmetic is exact.
  always_comb begin
    w_shift = {r_rem, r_quo[31]};
    w_ge    = (w_shift >= {1'b0, r_div});
    w_diff  = w_shift[16:0] - r_div;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_quo <= i_dividend;
        r_rem <= '0;
        r_div <= i_divisor;
        r_cnt <= '0;
        r_run <= 1'b1;
      end else if (r_run) begin
        r_quo <= {r_quo[30:0], w_ge};
        r_rem <= w_ge ? w_diff : w_shift[16:0];
        r_cnt <= r_cnt + 5'd1;
        if (r_cnt == 5'd31) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done      = r_done;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/unix_datetime_decoder.sv
// Multi-cycle decoder from unix seconds to UTC calendar date/time,
// valid for 1970-01-01 .. 2099-12-31.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of unix_datetime_decoder_if
//                start/unix_time in; busy/done/err and the decoded
//                year/month/day/hour/minute/second/weekday out
// Results are built in working registers and copied to the outputs in a
// single cycle, so partial values are never visible while busy.
module unix_datetime_decoder
  import unix_datetime_decoder_pkg::*;
#(
  parameter int N = 64
) (
  input logic                 clk,
  input logic                 reset,
  unix_datetime_decoder_if.slave bus
);

  // Widen to at least 33 bits so the upper-bits test always has a slice.
  localparam int W = (N > 32) ? N : 33;

  state_t r_state;
  state_t w_next;

  // Request and working registers
  logic [N-1:0] r_t;
  logic         r_bad;
  logic [31:0]  r_days;
  logic [16:0]  r_sod;
  logic [11:0]  r_w_year;
  logic [3:0]   r_w_month;
  logic [4:0]   r_w_day;
  logic [4:0]   r_w_hour;
  logic [5:0]   r_w_min;
  logic [5:0]   r_w_sec;
  logic [2:0]   r_acc;
  logic [5:0]   r_wsum;

  // Visible outputs
  logic         r_busy;
  logic         r_done;
  logic         r_err;
  logic [11:0]  r_year;
  logic [3:0]   r_month;
  logic [4:0]   r_day;
  logic [4:0]   r_hour;
  logic [5:0]   r_minute;
  logic [5:0]   r_second;
  logic [2:0]   r_weekday;

  logic [W-1:0] w_ext;
  logic         w_out_of_range;
  logic         w_accept;
  logic         w_leap;
  logic [31:0]  w_year_len;
  logic [4:0]   w_mon_len;
  logic [2:0]   w_mon_mod7;
  logic         w_div_start;
  logic         w_div_done;
  logic [31:0]  w_quo;
  logic [16:0]  w_rem;

  always_comb begin
    w_ext          = W'(r_t);
    w_out_of_range = (|w_ext[W-1:32]) || (w_ext[31:0] >= MAX_UNIX);
    // The r_done term blocks a start arriving in the same cycle as done.
    w_accept       = (r_state == IDLE) && bus.start && !r_done;
    w_leap         = (r_w_year[1:0] == 2'b00);
    w_year_len     = w_leap ? 32'd366 : 32'd365;
    w_mon_len      = month_len(r_w_month, w_leap);
    // Month lengths are 28..31, so length mod 7 is simply length - 28.
    w_mon_mod7     = 3'(w_mon_len - 5'd28);
    w_div_start    = (r_state == CHECK) && !w_out_of_range;
  end

  udiv_seq u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_div_start),
    .i_dividend (w_ext[31:0]),
    .i_divisor  (SEC_PER_DAY),
    .o_done     (w_div_done),
    .o_quotient (w_quo),
    .o_remainder(w_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CHECK;
      CHECK:   w_next = w_out_of_range ? DONE : DIVDAY;
      DIVDAY:  if (w_div_done) w_next = HOUR;
      HOUR:    if (r_sod < SEC_PER_HOUR) w_next = MIN;
      MIN:     if (r_sod < SEC_PER_MIN) w_next = YEAR;
      YEAR:    if (r_days < w_year_len) w_next = MONTH;
      MONTH:   if (r_days < 32'(w_mon_len)) w_next = WDAY;
      WDAY:    if (r_wsum < 6'd7) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_t       <= '0;
      r_bad     <= 1'b0;
      r_days    <= '0;
      r_sod     <= '0;
      r_w_year  <= EPOCH_YEAR;
      r_w_month <= 4'd1;
      r_w_day   <= 5'd1;
      r_w_hour  <= '0;
      r_w_min   <= '0;
      r_w_sec   <= '0;
      r_acc     <= EPOCH_WDAY;
      r_wsum    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_year    <= EPOCH_YEAR;
      r_month   <= 4'd1;
      r_day     <= 5'd1;
      r_hour    <= '0;
      r_minute  <= '0;
      r_second  <= '0;
      r_weekday <= EPOCH_WDAY;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_t    <= bus.unix_time;
            r_busy <= 1'b1;
            r_err  <= 1'b0;
          end
        end
        CHECK: begin
          r_bad     <= w_out_of_range;
          r_w_year  <= EPOCH_YEAR;
          r_w_month <= 4'd1;
          r_w_hour  <= '0;
          r_w_min   <= '0;
          r_acc     <= EPOCH_WDAY;
        end
        DIVDAY: begin
          if (w_div_done) begin
            r_days <= w_quo;
            r_sod  <= w_rem;
          end
        end
        HOUR: begin
          if (r_sod >= SEC_PER_HOUR) begin
            r_sod    <= r_sod - SEC_PER_HOUR;
            r_w_hour <= r_w_hour + 5'd1;
          end
        end
        MIN: begin
          if (r_sod >= SEC_PER_MIN) begin
            r_sod   <= r_sod - SEC_PER_MIN;
            r_w_min <= r_w_min + 6'd1;
          end else begin
            r_w_sec <= r_sod[5:0];
          end
        end
        YEAR: begin
          if (r_days >= w_year_len) begin
            r_days   <= r_days - w_year_len;
            r_w_year <= r_w_year + 12'd1;
            r_acc    <= mod7_add(r_acc, w_leap ? 3'd2 : 3'd1);
          end
        end
        MONTH: begin
          if (r_days >= 32'(w_mon_len)) begin
            r_days    <= r_days - 32'(w_mon_len);
            r_w_month <= r_w_month + 4'd1;
            r_acc     <= mod7_add(r_acc, w_mon_mod7);
          end else begin
            r_w_day <= r_days[4:0] + 5'd1;
            r_wsum  <= {3'b000, r_acc} + r_days[5:0];
          end
        end
        WDAY: begin
          if (r_wsum >= 6'd7) r_wsum <= r_wsum - 6'd7;
        end
        DONE: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_err  <= r_bad;
          if (!r_bad) begin
            r_year    <= r_w_year;
            r_month   <= r_w_month;
            r_day     <= r_w_day;
            r_hour    <= r_w_hour;
            r_minute  <= r_w_min;
            r_second  <= r_w_sec;
            r_weekday <= r_wsum[2:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.year    = r_year;
  assign bus.month   = r_month;
  assign bus.day     = r_day;
  assign bus.hour    = r_hour;
  assign bus.minute  = r_minute;
  assign bus.second  = r_second;
  assign bus.weekday = r_weekday;

endmodule

// File: tb/tb_unix_datetime_decoder.sv
// Scoreboard bench for unix_datetime_decoder: each request pushes its
// hand-computed result; a monitor pops and compares on every done pulse.
module tb_unix_datetime_decoder;

  typedef struct packed {
    logic        err;
    logic [11:0] year;
    logic [3:0]  month;
    logic [4:0]  day;
    logic [4:0]  hour;
    logic [5:0]  minute;
    logic [5:0]  second;
    logic [2:0]  weekday;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  unix_datetime_decoder_if #(.N(64)) bus ();

  unix_datetime_decoder #(.N(64)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t mk(input logic e, input int y, input int mo, input int d,
                              input int h, input int mi, input int s, input int w);
    exp_t r;
    r.err     = e;
    r.year    = 12'(y);
    r.month   = 4'(mo);
    r.day     = 5'(d);
    r.hour    = 5'(h);
    r.minute  = 6'(mi);
    r.second  = 6'(s);
    r.weekday = 3'(w);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_fields(input string tag, input exp_t e);
    check({tag, ".err"},     32'(bus.err),     32'(e.err));
    check({tag, ".year"},    32'(bus.year),    32'(e.year));
    check({tag, ".month"},   32'(bus.month),   32'(e.month));
    check({tag, ".day"},     32'(bus.day),     32'(e.day));
    check({tag, ".hour"},    32'(bus.hour),    32'(e.hour));
    check({tag, ".minute"},  32'(bus.minute),  32'(e.minute));
    check({tag, ".second"},  32'(bus.second),  32'(e.second));
    check({tag, ".weekday"}, 32'(bus.weekday), 32'(e.weekday));
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pulse at %0t", $time);
      end else begin
        mon_e = q.pop_front();
        check_fields("conv", mon_e);
        check("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
  end

  // hold_start keeps start asserted up to and including the done cycle,
  // exercising the ignore-while-busy and ignore-on-done rules.
  task automatic convert(input logic [63:0] t, input exp_t e, input bit hold_start);
    int cyc;
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.unix_time = t;
    q.push_back(e);
    if (!hold_start) begin
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.done !== 1'b1 && cyc < 400);
    if (bus.done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done after %0d cycles expected done", cyc);
      q.delete();
      bus.start = 1'b0;
    end else begin
      check("latency_le_300", 32'(cyc <= 300), 32'd1);
      if (hold_start) begin
        @(posedge clk);
        #1 bus.start = 1'b0;
      end
      @(negedge clk);
      check("done_one_cycle", 32'(bus.done), 32'd0);
      check("idle_after_done", 32'(bus.busy), 32'd0);
    end
  endtask

  exp_t rst_e;
  exp_t last_e;

  initial begin
    rst_e         = mk(1'b0, 1970, 1, 1, 0, 0, 0, 4);
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.unix_time = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_fields("reset", rst_e);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);

    convert(64'd0,          mk(1'b0, 1970, 1, 1, 0, 0, 0, 4), 1'b0);
    convert(64'd951782400,  mk(1'b0, 2000, 2, 29, 0, 0, 0, 2), 1'b0);
    convert(64'd1724550000, mk(1'b0, 2024, 8, 25, 1, 40, 0, 0), 1'b0);
    convert(64'd946684799,  mk(1'b0, 1999, 12, 31, 23, 59, 59, 5), 1'b0);
    convert(64'd946684800,  mk(1'b0, 2000, 1, 1, 0, 0, 0, 6), 1'b0);
    last_e = mk(1'b0, 2099, 12, 31, 23, 59, 59, 4);
    convert(64'd4102444799, last_e, 1'b1);

    // Out of range: err set, date/time untouched from the previous result.
    last_e.err = 1'b1;
    convert(64'd4102444800, last_e, 1'b0);
    convert(64'h0000_0001_0000_0000, last_e, 1'b0);

    // Abort: start at cycle 0, ignored start at cycle 5, reset at cycle 40.
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.unix_time = 64'd1724550000;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.unix_time = 64'd0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (34) @(posedge clk);
    #1;
    check("abort.busy_before_reset", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_fields("abort_reset", rst_e);
    check("abort_reset.busy", 32'(bus.busy), 32'd0);
    repeat (350) @(negedge clk);
    check("abort.no_pending", 32'(q.size()), 32'd0);

    convert(64'd86399, mk(1'b0, 1970, 1, 1, 23, 59, 59, 4), 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
